// File: rtl/ste_pulse_gen.sv
// Turns 1-cycle event strobes into fixed-length output pulses with a recovery gap.
// Strobes that arrive while a pulse is running wait in a saturating counter and replay back-to-back.
module ste_pulse_gen #(
    parameter int HIGH_CYC = 4,
    parameter int LOW_CYC  = 2,
    parameter int PEND_W   = 2,
    parameter bit POL      = 1'b1
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              trig_i,
    output logic              pulse_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pend_o,
    output logic              ovf_o
);

    localparam int CNT_MAX = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'((LOW_CYC > 0) ? LOW_CYC - 1 : 0);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic              NO_LOW    = (LOW_CYC == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    logic               cnt_done;
    logic               exiting;
    logic               have_req;
    logic               restart;
    logic               dequeue;
    logic               take_trig;
    logic               enqueue;
    logic [PEND_W-1:0]  pend_next;
    logic               ovf_next;

    // With no recovery phase, the end of HIGH is treated exactly like the end of LOW.
    assign cnt_done  = (cnt == '0);
    assign exiting   = cnt_done && ((state == LOW) || ((state == HIGH) && NO_LOW));
    assign have_req  = (pend_o != '0) || trig_i;
    assign restart   = exiting && have_req;
    assign dequeue   = restart && (pend_o != '0);
    assign take_trig = ((state == IDLE) && trig_i) || (restart && (pend_o == '0) && trig_i);
    assign enqueue   = trig_i && (state != IDLE) && !take_trig;

    always_comb begin
        pend_next = pend_o;
        ovf_next  = 1'b0;
        if (enqueue && !dequeue) begin
            if (pend_o == PEND_MAX) begin
                ovf_next = 1'b1;
            end else begin
                pend_next = pend_o + PEND_W'(1);
            end
        end else if (dequeue && !enqueue) begin
            pend_next = pend_o - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_o  <= '0;
            pulse_o <= ~POL;
            busy_o  <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            pend_o <= pend_next;
            ovf_o  <= ovf_next;
            case (state)
                IDLE: begin
                    if (trig_i) begin
                        state   <= HIGH;
                        cnt     <= HIGH_LOAD;
                        pulse_o <= POL;
                        busy_o  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (!cnt_done) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!NO_LOW) begin
                        state   <= LOW;
                        cnt     <= LOW_LOAD;
                        pulse_o <= ~POL;
                    end else if (have_req) begin
                        cnt     <= HIGH_LOAD;
                        pulse_o <= POL;
                    end else begin
                        state   <= IDLE;
                        pulse_o <= ~POL;
                        busy_o  <= 1'b0;
                    end
                end
                LOW: begin
                    if (!cnt_done) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (have_req) begin
                        state   <= HIGH;
                        cnt     <= HIGH_LOAD;
                        pulse_o <= POL;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    pulse_o <= ~POL;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
